// File: rtl/fb_write_engine_if.sv
// Command/response bundle for the framebuffer write engine.
// The master side offers commands and receives READ results;
// the slave side (the engine) accepts commands and returns results.
interface fb_write_engine_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_len,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_len,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/fb_write_engine.sv
// Framebuffer write engine.
// Turns WRITE / FILL / READ commands into accesses on port A of a
// single-port block RAM. WRITEs stream at one byte per cycle, FILLs
// write a run of identical bytes with address wrap, and READs wait
// out the RAM read latency before strobing the captured byte.
// Every RAM-side signal comes straight from a flop so the command
// inputs never reach the RAM combinationally.
module fb_write_engine #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clka,
    input  logic              reseta,
    fb_write_engine_if.slave  cmd,
    output logic              busy,
    output logic [ADDR_W-1:0] ada,
    output logic [DATA_W-1:0] dina,
    output logic              cea,
    output logic              wrea,
    output logic              ocea,
    input  logic [DATA_W-1:0] douta
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        RD_WAIT = 2'd2,
        RD_CAP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Largest run a FILL may request: the whole framebuffer.
    localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W - 1){1'b0}}, 1'b1};

    state_t            state_reg;
    logic [ADDR_W:0]   remain_reg;     // FILL writes still to issue after the current one
    logic [ADDR_W-1:0] ada_reg;
    logic [DATA_W-1:0] dina_reg;
    logic              cea_reg;
    logic              wrea_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;

    logic [ADDR_W:0]   len_next;       // requested FILL length, clamped to the framebuffer size
    logic [ADDR_W:0]   remain_next;    // remaining count after the first FILL write

    // Clamp oversized FILL requests so they cover the framebuffer exactly once.
    always_comb begin
        len_next    = (cmd.cmd_len > LEN_MAX) ? LEN_MAX : cmd.cmd_len;
        remain_next = (len_next == CNT_ZERO) ? CNT_ZERO : (len_next - CNT_ONE);
    end

    // Command sequencer: accepts commands in IDLE and drives all RAM-side and response flops.
    always_ff @(posedge clka or posedge reseta) begin
        if (reseta) begin
            state_reg     <= IDLE;
            remain_reg    <= CNT_ZERO;
            ada_reg       <= {ADDR_W{1'b0}};
            dina_reg      <= {DATA_W{1'b0}};
            cea_reg       <= 1'b0;
            wrea_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= {DATA_W{1'b0}};
        end else begin
            // RAM strobes and the response strobe are single-cycle unless re-armed below.
            cea_reg       <= 1'b0;
            wrea_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        case (cmd.cmd_op)
                            OP_WRITE: begin
                                // Single byte; stay in IDLE so the next WRITE can follow immediately.
                                ada_reg  <= cmd.cmd_addr;
                                dina_reg <= cmd.cmd_data;
                                cea_reg  <= 1'b1;
                                wrea_reg <= 1'b1;
                            end
                            OP_FILL: begin
                                // A zero-length FILL is consumed without touching the RAM.
                                if (len_next != CNT_ZERO) begin
                                    ada_reg    <= cmd.cmd_addr;
                                    dina_reg   <= cmd.cmd_data;
                                    cea_reg    <= 1'b1;
                                    wrea_reg   <= 1'b1;
                                    remain_reg <= remain_next;
                                    if (remain_next != CNT_ZERO) begin
                                        state_reg <= FILL;
                                    end
                                end
                            end
                            OP_READ: begin
                                ada_reg   <= cmd.cmd_addr;
                                cea_reg   <= 1'b1;
                                state_reg <= RD_WAIT;
                            end
                            default: begin
                                // Reserved opcode: accepted and dropped.
                            end
                        endcase
                    end
                end

                FILL: begin
                    // Address wraps naturally at the top of the framebuffer.
                    ada_reg    <= ada_reg + ADDR_ONE;
                    cea_reg    <= 1'b1;
                    wrea_reg   <= 1'b1;
                    remain_reg <= remain_reg - CNT_ONE;
                    // Return to IDLE during the final write so a new command can be taken right after it.
                    if (remain_reg == CNT_ONE) begin
                        state_reg <= IDLE;
                    end
                end

                RD_WAIT: begin
                    // RAM samples the read request at this edge; data appears in the following cycle.
                    state_reg <= RD_CAP;
                end

                RD_CAP: begin
                    rsp_data_reg  <= douta;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (state_reg == IDLE);
    assign cmd.rsp_valid = rsp_valid_reg;
    assign cmd.rsp_data  = rsp_data_reg;
    assign busy          = (state_reg != IDLE);
    assign ada           = ada_reg;
    assign dina          = dina_reg;
    assign cea           = cea_reg;
    assign wrea          = wrea_reg;
    assign ocea          = 1'b1;

endmodule
